// File: rtl/lsu_dmem_port.sv
// ----------------------------------------------------------------------------
// lsu_dmem_port
//   Load/store unit port to a byte-lane data memory with a one-cycle read
//   latency. Accepts one access at a time over a valid/ready request channel.
//   It checks alignment, positions store data onto byte lanes, and extracts
//   and extends load data. It returns a single response over a valid/ready
//   response channel.
//
//   Request : req_valid_i, req_ready_o, req_we_i, req_size_i (00 B, 01 H,
//             10 W, 11 reserved), req_signed_i, req_addr_i, req_wdata_i
//   Response: resp_valid_o, resp_ready_i, resp_rdata_o, resp_err_o
//   Memory  : mem_we_o (per byte lane), mem_addr_o, mem_wdata_o, mem_rdata_i
//             (read word valid the cycle after the address is presented)
//
//   Flow: IDLE -> ISSUE -> RESP                  (store, 2 cycles)
//         IDLE -> ISSUE -> WAIT -> RESP          (load,  3 cycles)
//         IDLE -> RESP                           (error, 1 cycle)
// ----------------------------------------------------------------------------
module lsu_dmem_port #(
    parameter int DATA_WIDTH = 32,
    parameter int DMEM_DEPTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    input  logic [DMEM_DEPTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic [3:0]            mem_we_o,
    output logic [DMEM_DEPTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t     state;

    // Request fields needed after acceptance (load lane select and extension).
    logic       req_we_q;
    logic [1:0] req_size_q;
    logic       req_signed_q;
    logic [1:0] addr_lo_q;

    logic                  req_fire;
    logic                  req_err;
    logic [3:0]            store_be;
    logic [DATA_WIDTH-1:0] store_data;
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [DATA_WIDTH-1:0] load_data;

    assign req_fire = req_valid_i && req_ready_o;

    // Reserved size or natural-alignment violation on the incoming request.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        req_err = 1'b0;
        case (req_size_i)
            SIZE_BYTE: req_err = 1'b0;
            SIZE_HALF: req_err = req_addr_i[0];
            SIZE_WORD: req_err = (req_addr_i[1:0] != 2'b00);
            default:   req_err = 1'b1;
        endcase
    end

    // Lane enables and lane-replicated write data; the enables pick the lanes.
    always_comb begin
        store_be   = 4'b1111;
        store_data = req_wdata_i;
        case (req_size_i)
            SIZE_BYTE: begin
                store_be   = 4'b0001 << req_addr_i[1:0];
                store_data = {4{req_wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                store_be   = req_addr_i[1] ? 4'b1100 : 4'b0011;
                store_data = {2{req_wdata_i[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = req_wdata_i;
            end
        endcase
    end

    // Load lane extraction from the registered address, then extension.
    always_comb begin
        load_byte = mem_rdata_i[{addr_lo_q, 3'b000} +: 8];
        load_half = addr_lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_data = mem_rdata_i;
        case (req_size_q)
            SIZE_BYTE: load_data = {{(DATA_WIDTH-8){req_signed_q & load_byte[7]}}, load_byte};
            SIZE_HALF: load_data = {{(DATA_WIDTH-16){req_signed_q & load_half[15]}}, load_half};
            default:   load_data = mem_rdata_i;
        endcase
    end

    // Single FSM process; every output is a register so the async reset
    // clears mem_we_o immediately, aborting an in-flight store.
    // NOTE: all state is assigned with <= so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
            mem_we_o     <= 4'b0000;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            req_we_q     <= 1'b0;
            req_size_q   <= 2'b00;
            req_signed_q <= 1'b0;
            addr_lo_q    <= 2'b00;
        end else begin
            // Write enables live for the single ISSUE cycle only.
            mem_we_o <= 4'b0000;

            case (state)
                IDLE: begin
                    if (req_fire) begin
                        req_ready_o  <= 1'b0;
                        req_we_q     <= req_we_i;
                        req_size_q   <= req_size_i;
                        req_signed_q <= req_signed_i;
                        addr_lo_q    <= req_addr_i[1:0];
                        if (req_err) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end else begin
                            state      <= ISSUE;
                            mem_addr_o <= req_addr_i;
                            if (req_we_i) begin
                                mem_we_o    <= store_be;
                                mem_wdata_o <= store_data;
                            end
                        end
                    end
                end

                ISSUE: begin
                    if (req_we_q) begin
                        state        <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= '0;
                    end else begin
                        state <= WAIT;
                    end
                end

                // mem_rdata_i now reflects the address presented during ISSUE.
                WAIT: begin
                    state        <= RESP;
                    resp_valid_o <= 1'b1;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= load_data;
                end

                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        req_ready_o  <= 1'b1;
                        resp_valid_o <= 1'b0;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// ----------------------------------------------------------------------------
// tb_lsu_dmem_port
//   Self-checking bench for lsu_dmem_port. Contains a byte-array data memory
//   with a one-cycle read that the DUT drives. A table of directed vectors
//   covers the documented corner cases. Random accesses are then compared
//   against a byte-addressed reference memory that applies the
//   load/store/alignment rules directly.
// ----------------------------------------------------------------------------
module tb_lsu_dmem_port;

    localparam int DW = 32;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [1:0]    req_size_i;
    logic          req_signed_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic [DW-1:0] resp_rdata_o;
    logic          resp_err_o;
    logic [3:0]    mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    lsu_dmem_port #(.DATA_WIDTH(DW), .DMEM_DEPTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_size_i   (req_size_i),
        .req_signed_i (req_signed_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    // ---------------- data memory seen by the DUT ----------------
    logic [7:0]  tb_mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (pre_en)
                tb_mem[{pre_addr[7:2], k[1:0]}] <= pre_data[8*k +: 8];
            if (mem_we_o[k])
                tb_mem[{mem_addr_o[7:2], k[1:0]}] <= mem_wdata_o[8*k +: 8];
        end
        mem_rdata_i <= {tb_mem[{mem_addr_o[7:2], 2'd3}], tb_mem[{mem_addr_o[7:2], 2'd2}],
                        tb_mem[{mem_addr_o[7:2], 2'd1}], tb_mem[{mem_addr_o[7:2], 2'd0}]};
    end

    // ---------------- reference memory ----------------
    logic [7:0] ref_mem [0:255];

    // Reference behaviour: an access of 2**size bytes must be naturally aligned.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic sgn,
                              input int addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err, output int lat);
        int nb;
        logic [31:0] val;
        nb = 1 << size;
        rdata = 32'h0;
        err = (size == 2'b11) || ((addr % nb) != 0);
        if (err) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            lat = 2;
        end else begin
            val = 32'h0;
            for (int i = 0; i < nb; i++) val = val | ({24'h0, ref_mem[addr + i]} << (8*i));
            if (sgn && nb < 4 && val[8*nb - 1]) val = val | ~((32'h1 << (8*nb)) - 32'h1);
            rdata = val;
            lat = 3;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_en = 1'b1;
        pre_addr = a;
        pre_data = d;
        cycle();
        pre_en = 1'b0;
    endtask

    task automatic noise();
        req_valid_i  = 1'($urandom);
        req_we_i     = 1'($urandom);
        req_size_i   = 2'($urandom);
        req_signed_i = 1'($urandom);
        req_addr_i   = 14'($urandom);
        req_wdata_i  = $urandom;
    endtask

    // Drives one request, follows it to its response, holds the response for
    // 'hold' cycles while noise is applied on the request side, then handshakes.
    task automatic run_req(input string name, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [13:0] addr, input logic [31:0] wdata,
                           input int hold,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output logic [3:0] we_or, output int we_cycles,
                           output logic [31:0] wd_seen, output logic [13:0] ad_seen,
                           output logic stable);
        rdata = 32'h0; err = 1'b0; lat = 0; we_or = 4'h0; we_cycles = 0;
        wd_seen = 32'h0; ad_seen = 14'h0; stable = 1'b1;
        check({name, "_ready"}, 32'(req_ready_o), 32'h1);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_signed_i = sgn;
        req_addr_i = addr; req_wdata_i = wdata;
        cycle();
        req_valid_i = 1'b0;
        forever begin
            lat++;
            if (lat == 1) ad_seen = mem_addr_o;
            if (mem_we_o != 4'h0) begin
                we_or = we_or | mem_we_o;
                we_cycles++;
                wd_seen = mem_wdata_o;
            end
            if (resp_valid_o) break;
            if (lat >= 20) begin
                check({name, "_timeout"}, 32'(resp_valid_o), 32'h1);
                return;
            end
            noise();
            cycle();
        end
        rdata = resp_rdata_o;
        err = resp_err_o;
        for (int h = 0; h < hold; h++) begin
            noise();
            cycle();
            if (resp_rdata_o !== rdata || resp_err_o !== err || resp_valid_o !== 1'b1 ||
                req_ready_o !== 1'b0 || mem_we_o !== 4'h0 || (we_cycles == 0 && mem_addr_o !== ad_seen))
                stable = 1'b0;
        end
        req_valid_i = 1'b0;
        resp_ready_i = 1'b1;
        cycle();
        resp_ready_i = 1'b0;
        check({name, "_idle"}, {30'h0, resp_valid_o, req_ready_o}, 32'h1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic [3:0]  e_we;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] rdata, e_rdata, wd_seen;
        logic        err, e_err, stable;
        logic [3:0]  we_or;
        logic [13:0] ad_seen;
        int          lat, e_lat, we_cycles;

        vecs[0]  = '{1'b1, 2'b00, 1'b0, 14'h0006, 32'h000000A5, 32'h0,        4'b0100, 32'hA5A5A5A5, 32'h0,        1'b0, 2};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 14'h0003, 32'h0,        32'h80123456, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0, 3};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 14'h0003, 32'h0,        32'h80123456, 4'b0000, 32'h0,        32'h00000080, 1'b0, 3};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 14'h0002, 32'h0,        32'h7FFF0000, 4'b0000, 32'h0,        32'h00007FFF, 1'b0, 3};
        vecs[4]  = '{1'b0, 2'b10, 1'b1, 14'h0004, 32'h0,        32'hDEADBEEF, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 14'h0002, 32'h11223344, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1};
        vecs[6]  = '{1'b0, 2'b11, 1'b0, 14'h0000, 32'h0,        32'h12345678, 4'b0000, 32'h0,        32'h0,        1'b1, 1};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 14'h0002, 32'h1234ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0,        1'b0, 2};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 14'h0001, 32'h0,        32'hFFFFFFFF, 4'b0000, 32'h0,        32'h0,        1'b1, 1};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 14'h0000, 32'h0,        32'h00008001, 4'b0000, 32'h0,        32'hFFFF8001, 1'b0, 3};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 14'h0001, 32'hFFFFFF3C, 32'h0,        4'b0010, 32'h3C3C3C3C, 32'h0,        1'b0, 2};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 14'h0000, 32'h00005555, 32'h0,        4'b0011, 32'h55555555, 32'h0,        1'b0, 2};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 14'h0009, 32'h0,        32'h00009100, 4'b0000, 32'h0,        32'h00000091, 1'b0, 3};

        rst_n = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_signed_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; resp_ready_i = 1'b0;
        pre_en = 1'b0; pre_addr = 8'h0; pre_data = 32'h0;

        // Reset state
        cycle();
        cycle();
        check("rst_ready",  32'(req_ready_o),  32'h1);
        check("rst_resp",   {30'h0, resp_valid_o, resp_err_o}, 32'h0);
        check("rst_rdata",  resp_rdata_o, 32'h0);
        check("rst_mem_we", 32'(mem_we_o), 32'h0);
        check("rst_addr",   32'(mem_addr_o), 32'h0);
        check("rst_wdata",  mem_wdata_o, 32'h0);
        rst_n = 1'b1;
        cycle();

        // Directed table
        for (int i = 0; i < 13; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            if (!vecs[i].we) preload({vecs[i].addr[7:2], 2'b00}, vecs[i].pre);
            run_req(nm, vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, i % 3,
                    rdata, err, lat, we_or, we_cycles, wd_seen, ad_seen, stable);
            check({nm, "_lat"},   32'(lat), 32'(vecs[i].e_lat));
            check({nm, "_err"},   32'(err), 32'(vecs[i].e_err));
            check({nm, "_rdata"}, rdata, vecs[i].e_rdata);
            check({nm, "_we"},    32'(we_or), 32'(vecs[i].e_we));
            check({nm, "_we_cycles"}, 32'(we_cycles), (vecs[i].e_we != 4'h0) ? 32'h1 : 32'h0);
            if (vecs[i].e_we != 4'h0) check({nm, "_wdata"}, wd_seen, vecs[i].e_wdata);
            if (!vecs[i].e_err) check({nm, "_addr"}, 32'(ad_seen), 32'(vecs[i].addr));
            check({nm, "_stable"}, 32'(stable), 32'h1);
        end

        // Long response stall with request noise: response held, no new access
        preload(8'h10, 32'hA1B2C3D4);
        run_req("stall", 1'b0, 2'b01, 1'b0, 14'h0012, 32'h0, 5,
                rdata, err, lat, we_or, we_cycles, wd_seen, ad_seen, stable);
        check("stall_rdata",  rdata, 32'h0000A1B2);
        check("stall_stable", 32'(stable), 32'h1);
        check("stall_we",     32'(we_or), 32'h0);

        // Random accesses against the reference memory
        for (int w = 0; w < 64; w++) begin
            logic [31:0] d;
            d = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = d[8*b +: 8];
            preload(8'(4*w), d);
        end
        for (int n = 0; n < 150; n++) begin
            logic        r_we, r_sgn;
            logic [1:0]  r_size;
            logic [31:0] r_wdata;
            int          r_addr;
            string       nm;
            r_we = 1'($urandom);
            r_sgn = 1'($urandom);
            r_size = 2'($urandom_range(0, 3));
            r_addr = int'($urandom_range(0, 63));
            r_wdata = $urandom;
            nm = $sformatf("r%0d", n);
            ref_access(r_we, r_size, r_sgn, r_addr, r_wdata, e_rdata, e_err, e_lat);
            run_req(nm, r_we, r_size, r_sgn, 14'(r_addr), r_wdata, int'($urandom_range(0, 2)),
                    rdata, err, lat, we_or, we_cycles, wd_seen, ad_seen, stable);
            check({nm, "_rdata"}, rdata, e_rdata);
            check({nm, "_err"},   32'(err), 32'(e_err));
            check({nm, "_lat"},   32'(lat), 32'(e_lat));
            check({nm, "_we_cycles"}, 32'(we_cycles), (r_we && !e_err) ? 32'h1 : 32'h0);
        end

        // Reset mid-ISSUE of a word store aborts the write asynchronously
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_signed_i = 1'b0;
        req_addr_i = 14'h0008; req_wdata_i = 32'hCAFEF00D;
        cycle();
        req_valid_i = 1'b0;
        check("abort_issue_we", 32'(mem_we_o), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_we_async", 32'(mem_we_o), 32'h0);
        check("abort_ready",    32'(req_ready_o), 32'h1);
        check("abort_outs",     {30'h0, resp_valid_o, resp_err_o}, 32'h0);
        check("abort_addr",     32'(mem_addr_o), 32'h0);
        check("abort_wdata",    mem_wdata_o | resp_rdata_o, 32'h0);
        cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check($sformatf("abort_noresp%0d", c), {29'h0, resp_valid_o, req_ready_o, |mem_we_o}, 32'h2);
        end
        check("abort_nowrite", {tb_mem[11], tb_mem[10], tb_mem[9], tb_mem[8]},
              {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_dmem_port.md
LSU_DMEM_PORT -- requirements
Module: lsu_dmem_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data word width in bits (only 32 supported).
REQ-002 SHALL have parameter DMEM_DEPTH, default 14, meaning byte-address width of the data memory.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid_i  input  1  access request valid.
REQ-006 SHALL have port req_ready_o  output  1  block can accept a request.
REQ-007 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size_i  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SHALL have port req_signed_i  input  1  load extension: 1 = sign-extend, 0 = zero-extend.
REQ-010 SHALL have port req_addr_i  input  DMEM_DEPTH  byte address.
REQ-011 SHALL have port req_wdata_i  input  DATA_WIDTH  store data, right-justified.
REQ-012 SHALL have port resp_valid_o  output  1  response valid.
REQ-013 SHALL have port resp_ready_i  input  1  consumer accepts the response.
REQ-014 SHALL have port resp_rdata_o  output  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err_o  output  1  misaligned or reserved-size access.
REQ-016 SHALL have port mem_we_o  output  4  per-byte-lane write enable to data memory.
REQ-017 SHALL have port mem_addr_o  output  DMEM_DEPTH  byte address to data memory.
REQ-018 SHALL have port mem_wdata_o  output  DATA_WIDTH  lane-positioned write data; lane k = bits [8k+7:8k].
REQ-019 SHALL have port mem_rdata_i  input  DATA_WIDTH  memory read word, valid one cycle after address; lane k = bits [8k+7:8k].

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-021 SHALL drive req_ready_o = 1 only in IDLE; a request is accepted when req_valid_i && req_ready_o at a rising edge, and all request fields are registered then.
REQ-022 SHALL flag an error when size = 11, halfword with addr[0] = 1, or word with addr[1:0] != 00.
REQ-023 On an accepted error request, SHALL go IDLE -> RESP with resp_err_o = 1 and resp_rdata_o = 0, with no memory access (mem_we_o stays 0000).
REQ-024 On an accepted valid request, SHALL go IDLE -> ISSUE and, for exactly that one ISSUE cycle, drive mem_addr_o and mem_we_o/mem_wdata_o from the registered request.
REQ-025 Byte store SHALL assert mem_we_o = 1 << addr[1:0] and replicate wdata[7:0] onto all four lanes.
REQ-026 Halfword store SHALL assert mem_we_o = 0011 (addr[1] = 0) or 1100 (addr[1] = 1) and replicate wdata[15:0] onto both halves.
REQ-027 Word store SHALL assert mem_we_o = 1111 with mem_wdata_o = wdata.
REQ-028 mem_we_o SHALL be 0000 in every state except ISSUE of a store.
REQ-029 mem_addr_o SHALL hold its last registered value outside ISSUE.
REQ-030 Store SHALL go ISSUE -> RESP with resp_rdata_o = 0 and resp_err_o = 0.
REQ-031 Load SHALL go ISSUE -> WAIT -> RESP; at the end of WAIT, SHALL capture the lane(s) selected by the registered addr[1:0] from mem_rdata_i.
REQ-032 Load data SHALL be extended to 32 bits per req_signed_i (bit 7 for byte, bit 15 for halfword); word loads SHALL ignore req_signed_i.
REQ-033 In RESP, resp_valid_o SHALL be 1, and resp_rdata_o/resp_err_o SHALL be stable until resp_valid_o && resp_ready_i at a rising edge, then go to IDLE.
REQ-034 Latency from acceptance edge to the first resp_valid_o cycle SHALL be: error 1 cycle, store 2 cycles, load 3 cycles.
REQ-035 Only one request SHALL be outstanding at a time; req_valid_i outside IDLE SHALL be ignored.

Reset
REQ-036 While rst_n = 0, SHALL force state to IDLE and req_ready_o = 1, with resp_valid_o, resp_err_o, resp_rdata_o, mem_we_o, mem_addr_o and mem_wdata_o all 0.
REQ-037 Reset asserted in any state, including mid-ISSUE, SHALL abort the access immediately (mem_we_o = 0000 asynchronously) with no response produced.

Verification
REQ-038 Byte store at addr 0x0006 with wdata 0x000000A5 -> ISSUE cycle shows mem_we_o = 0100 and mem_wdata_o = 0xA5A5A5A5; resp_valid_o 2 cycles after acceptance, err = 0.
REQ-039 Signed byte load at addr 0x0003 with mem_rdata_i = 0x80123456 in WAIT -> resp_rdata_o = 0xFFFFFF80; unsigned -> 0x00000080; resp_valid_o 3 cycles after acceptance.
REQ-040 Signed halfword load at addr 0x0002 with mem_rdata_i = 0x7FFF0000 -> resp_rdata_o = 0x00007FFF; a word load at 0x0004 returns mem_rdata_i unchanged.
REQ-041 Word store at addr 0x0002, and size = 11 at addr 0x0000 -> resp_err_o = 1 one cycle after acceptance, resp_rdata_o = 0, mem_we_o = 0000 throughout.
REQ-042 Hold resp_ready_i = 0 for 5 cycles in RESP while toggling req_valid_i -> response stable, req_ready_o = 0, no new access; IDLE one cycle after the handshake.
REQ-043 Assert rst_n = 0 during ISSUE of a word store -> mem_we_o drops to 0000 without waiting for a clock edge; after release, state is IDLE with all outputs at reset values.
